// File: rtl/ps2_keys_pkg.sv
// ps2_keys_pkg: set-2 scancode constants, parser states and game-key lookup
// shared by the keycode decoder and its event FIFO.
package ps2_keys_pkg;

    localparam int EV_W = 11;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_E1 = 8'hE1;
    localparam logic [7:0] SC_FA = 8'hFA;
    localparam logic [7:0] SC_AA = 8'hAA;
    localparam logic [7:0] SC_EE = 8'hEE;
    localparam logic [7:0] SC_FE = 8'hFE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } parse_state_e;

    // Controller status/ack bytes that never carry a key.
    function automatic logic is_status(input logic [7:0] code);
        return code == SC_FA || code == SC_AA || code == SC_EE ||
               code == SC_FE || code == 8'h00 || code == 8'hFF;
    endfunction

    // Returns {hit, idx[2:0]} into the held/press bitmaps.
    function automatic logic [3:0] game_key_idx(input logic ext, input logic [7:0] code);
        case ({ext, code})
            {1'b1, 8'h6B}: game_key_idx = 4'b1000;
            {1'b1, 8'h74}: game_key_idx = 4'b1001;
            {1'b1, 8'h75}: game_key_idx = 4'b1010;
            {1'b1, 8'h72}: game_key_idx = 4'b1011;
            {1'b0, 8'h29}: game_key_idx = 4'b1100;
            {1'b0, 8'h76}: game_key_idx = 4'b1101;
            {1'b0, 8'h5A}: game_key_idx = 4'b1110;
            {1'b0, 8'h4D}: game_key_idx = 4'b1111;
            default:       game_key_idx = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous event FIFO with wrap-bit pointers; a pop on a
// full FIFO frees the slot for a push on the same cycle.
module ps2_event_fifo
    import ps2_keys_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [EV_W-1:0] din,
    output logic [EV_W-1:0] dout,
    output logic            full,
    output logic            empty
);
    localparam int AW = $clog2(DEPTH);

    logic [EV_W-1:0] mem_q [DEPTH];
    logic [AW:0]     wr_q, wr_d, rd_q, rd_d;
    logic            do_push, do_pop;

    always_comb begin
        empty   = wr_q == rd_q;
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = do_push ? wr_q + (AW+1)'(1) : wr_q;
        rd_d    = do_pop ? rd_q + (AW+1)'(1) : rd_q;
        dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_keycode_decoder.sv
// ps2_keycode_decoder: parses set-2 scancode bytes into make/break events,
// tracks held/pressed game keys and flags prefix timeouts or malformed input.
module ps2_keycode_decoder
    import ps2_keys_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic [7:0]  received_data,
    input  logic        received_data_en,
    output logic [10:0] ev_data,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [7:0]  key_held,
    output logic [7:0]  key_press,
    output logic        ev_overflow,
    output logic        seq_error
);
    localparam int            TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    rst_sync_q;
    logic          rst_n;
    parse_state_e  state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    key_held_q, key_held_d, key_press_q, key_press_d;
    logic          ev_overflow_q, ev_overflow_d, seq_error_q, seq_error_d;
    logic          push, pop, full, empty, ev_ext, ev_brk, rpt;
    logic [3:0]    gk;
    logic [10:0]   ev_word;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        tmo_d       = tmo_q;
        push        = 1'b0;
        ev_ext      = 1'b0;
        ev_brk      = 1'b0;
        seq_error_d = 1'b0;
        if (received_data_en) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (received_data == SC_E0) state_d = ST_EXT;
                    else if (received_data == SC_F0) state_d = ST_BRK;
                    else if (received_data == SC_E1) begin
                        state_d = ST_PAUSE;
                        skip_d  = 3'd7;
                    end else push = !is_status(received_data);
                end
                ST_EXT: begin
                    state_d     = (received_data == SC_F0) ? ST_EXT_BRK : ST_IDLE;
                    seq_error_d = received_data == SC_E0;
                    push        = received_data != SC_F0 && received_data != SC_E0;
                    ev_ext      = 1'b1;
                end
                ST_BRK, ST_EXT_BRK: begin
                    state_d     = ST_IDLE;
                    seq_error_d = received_data == SC_E0 || received_data == SC_F0;
                    push        = !seq_error_d;
                    ev_ext      = state_q == ST_EXT_BRK;
                    ev_brk      = 1'b1;
                end
                ST_PAUSE: begin
                    skip_d  = skip_q - 3'd1;
                    state_d = (skip_q == 3'd1) ? ST_IDLE : ST_PAUSE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            tmo_d = tmo_q + TW'(1);
            if (tmo_q == TMO_LAST) begin
                tmo_d       = '0;
                state_d     = ST_IDLE;
                seq_error_d = 1'b1;
            end
        end
    end

    always_comb begin
        gk          = game_key_idx(ev_ext, received_data);
        rpt         = gk[3] && !ev_brk && key_held_q[gk[2:0]];
        key_held_d  = key_held_q;
        key_press_d = '0;
        if (push && gk[3]) begin
            key_held_d[gk[2:0]]  = !ev_brk;
            key_press_d[gk[2:0]] = !ev_brk && !rpt;
        end
        ev_word       = {rpt, ev_ext, ev_brk, received_data};
        pop           = !empty && ev_ready;
        ev_overflow_d = ev_overflow_q || (push && full && !pop);
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            skip_q        <= '0;
            tmo_q         <= '0;
            key_held_q    <= '0;
            key_press_q   <= '0;
            ev_overflow_q <= 1'b0;
            seq_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            skip_q        <= skip_d;
            tmo_q         <= tmo_d;
            key_held_q    <= key_held_d;
            key_press_q   <= key_press_d;
            ev_overflow_q <= ev_overflow_d;
            seq_error_q   <= seq_error_d;
        end
    end

    ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (ev_word),
        .dout  (ev_data),
        .full  (full),
        .empty (empty)
    );

    assign ev_valid    = !empty;
    assign key_held    = key_held_q;
    assign key_press   = key_press_q;
    assign ev_overflow = ev_overflow_q;
    assign seq_error   = seq_error_q;

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// tb_ps2_keycode_decoder: directed scancode sequences; expected events go into
// a queue that a negedge monitor pops and compares on every FIFO pop.
module tb_ps2_keycode_decoder;
    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, ready = 1'b1;
    logic [7:0]  d = 8'h00;
    logic [10:0] ev_data;
    logic        ev_valid, ev_overflow, seq_error;
    logic [7:0]  key_held, key_press;
    int          n_cmp = 0, n_fail = 0;
    logic [10:0] exp_q [$];

    always #5 clk = ~clk;

    ps2_keycode_decoder #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
        .CLOCK_50         (clk),
        .reset_n          (rst_n),
        .received_data    (d),
        .received_data_en (en),
        .ev_data          (ev_data),
        .ev_valid         (ev_valid),
        .ev_ready         (ready),
        .key_held         (key_held),
        .key_press        (key_press),
        .ev_overflow      (ev_overflow),
        .seq_error        (seq_error)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        d = b; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(negedge clk);
        if (ev_valid && ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL ev_unexpected: got %0h expected none", ev_data);
            end else chk("ev_data", ev_data, exp_q.pop_front());
        end
    end

    initial begin
        int k;
        #22;
        chk("rst_ev_valid", ev_valid, 0);
        chk("rst_ev_data", ev_data, 0);
        chk("rst_key_held", key_held, 0);
        chk("rst_key_press", key_press, 0);
        chk("rst_overflow", ev_overflow, 0);
        chk("rst_seq_error", seq_error, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        exp_q.push_back(11'h01C); send(8'h1C);
        chk("mk_held", key_held, 0);
        exp_q.push_back(11'h11C); send(8'hF0); send(8'h1C);
        chk("brk_held", key_held, 0);

        exp_q.push_back(11'h26B); send(8'hE0); send(8'h6B);
        chk("left_press", key_press, 8'h01);
        chk("left_held", key_held, 8'h01);
        exp_q.push_back(11'h66B); send(8'hE0); send(8'h6B);
        chk("left_rpt_press", key_press, 8'h00);
        exp_q.push_back(11'h36B); send(8'hE0); send(8'hF0); send(8'h6B);
        chk("left_brk_held", key_held, 8'h00);
        drain();

        send(8'hAA); send(8'hFA);
        chk("status_no_ev", ev_valid, 0);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        chk("pause_no_ev", ev_valid, 0);
        chk("pause_held", key_held, 0);
        exp_q.push_back(11'h029); send(8'h29);
        chk("space_press", key_press, 8'h10);
        exp_q.push_back(11'h129); send(8'hF0); send(8'h29);
        chk("space_brk_held", key_held, 8'h00);

        send(8'hE0);
        for (k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (seq_error) break;
        end
        chk("tmo_cycles", k, 64);
        @(posedge clk); #1;
        chk("tmo_pulse_once", seq_error, 0);
        exp_q.push_back(11'h075); send(8'h75);
        chk("tmo_next_held", key_held, 8'h00);

        send(8'hE0); send(8'hE0);
        chk("bad_e0e0", seq_error, 1);
        send(8'hF0); send(8'hF0);
        chk("bad_f0f0", seq_error, 1);
        exp_q.push_back(11'h01C); send(8'h1C);
        chk("bad_after_err", seq_error, 0);
        drain();

        ready = 1'b0;
        exp_q.push_back(11'h015); send(8'h15);
        exp_q.push_back(11'h01D); send(8'h1D);
        exp_q.push_back(11'h024); send(8'h24);
        exp_q.push_back(11'h02D); send(8'h2D);
        chk("full_no_ovf", ev_overflow, 0);
        exp_q.push_back(11'h02C);
        @(posedge clk); #1;
        d = 8'h2C; en = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        chk("simul_no_ovf", ev_overflow, 0);
        drain();

        ready = 1'b0;
        exp_q.push_back(11'h016); send(8'h16);
        exp_q.push_back(11'h01E); send(8'h1E);
        exp_q.push_back(11'h026); send(8'h26);
        exp_q.push_back(11'h025); send(8'h25);
        send(8'h2E);
        chk("ovf_set", ev_overflow, 1);
        chk("ovf_head_stable", ev_data, 11'h016);
        ready = 1'b1;
        drain();
        chk("ovf_sticky", ev_overflow, 1);

        ready = 1'b0;
        send(8'h29); send(8'h15);
        chk("pre_rst_held", key_held, 8'h10);
        send(8'hE0); send(8'hF0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ev_valid", ev_valid, 0);
        chk("arst_key_held", key_held, 0);
        chk("arst_overflow", ev_overflow, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; ready = 1'b1;
        repeat (3) @(posedge clk);
        exp_q.push_back(11'h06B); send(8'h6B);
        drain();
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_keycode_decoder.md
Name: ps2_keycode_decoder

Overview:
- Downstream consumer of the PS/2 controller's `received_data`/`received_data_en` byte stream.
- Parses keyboard set-2 scancodes: E0 extended prefix, F0 break prefix, E1 pause sequence, controller status bytes.
- Emits decoded make/break events through a small valid/ready FIFO.
- Keeps a held-key bitmap and one-cycle press pulses for the eight game keys used by the Tetris core.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16.
- TIMEOUT_CYCLES, 100000, CLOCK_50 cycles allowed between a prefix byte and its follow-up (2 ms at 50 MHz); minimum 2.

Ports:
- CLOCK_50  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- received_data  in  8  byte from the PS/2 controller.
- received_data_en  in  1  one-cycle strobe; `received_data` is valid while high.
- ev_data  out  11  {repeat, ext, brk, code[7:0]}, head of the FIFO.
- ev_valid  out  1  FIFO not empty.
- ev_ready  in  1  consumer pop; a pop happens when `ev_valid & ev_ready`.
- key_held  out  8  held bitmap: [0] Left E0 6B, [1] Right E0 74, [2] Up E0 75, [3] Down E0 72, [4] Space 29, [5] Esc 76, [6] Enter 5A, [7] P 4D.
- key_press  out  8  one-cycle pulse, per bit, on the first make of a game key.
- ev_overflow  out  1  sticky; set when an event is dropped because the FIFO is full.
- seq_error  out  1  one-cycle pulse on prefix timeout or malformed sequence.

Behaviour:
- Reset (async assert, sync deassert inside the block): parser IDLE, FIFO empty.
- Reset values: `ev_valid`=0, `ev_data`=0, `key_held`=0, `key_press`=0, `ev_overflow`=0, `seq_error`=0, timeout counter 0.
- Bytes are consumed only on cycles with `received_data_en`=1. All other bytes are ignored.
- Parser states and transitions:
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> PAUSE, with skip counter=7.
    - FA, AA, EE, FE, 00, FF -> discarded, stay in IDLE.
    - Any other byte -> emit event {ext=0, brk=0, code}.
  - EXT: F0 -> EXT_BRK. Any other byte -> emit {ext=1, brk=0}, then IDLE.
  - BRK: emit {ext=0, brk=1, code}, then IDLE.
  - EXT_BRK: emit {ext=1, brk=1, code}, then IDLE.
  - PAUSE: decrement the skip counter on each byte; return to IDLE after the 7th byte. Nothing is emitted and `key_held` is unaffected.
  - Prefix bytes inside a prefix state (E0 or F0 in BRK/EXT_BRK, E0 in EXT) are malformed: pulse `seq_error`, go to IDLE, discard the byte. The byte is not re-parsed.
- Timeout:
  - The counter runs in EXT, BRK, EXT_BRK and PAUSE. It clears on every accepted byte and on entry to IDLE.
  - At TIMEOUT_CYCLES-1: pulse `seq_error`, go to IDLE.
  - If a byte strobe lands on the timeout cycle, the byte wins and the timeout is ignored.
- Latency: strobe at cycle N -> FIFO write, `key_held` update and `key_press` pulse all visible at N+1. `ev_valid` rises at N+1 when the FIFO was empty.
- Repeat flag:
  - repeat=1 when a make matches a game key whose `key_held` bit is already 1.
  - The event is still enqueued, but `key_press` does not pulse.
  - Non-game makes always carry repeat=0.
- Held map: a break of a game key clears its bit. A break of a key that is not held is enqueued normally, with no error.
- FIFO:
  - Registered pointers with an extra wrap bit; count range 0..FIFO_DEPTH.
  - Simultaneous push and pop when full: the pop frees a slot and the push succeeds.
  - Push when full with no pop: drop the event and set `ev_overflow`. `ev_overflow` clears only on reset.
  - Pop when empty: no effect.
  - `ev_data` is held stable while `ev_valid` & !`ev_ready`.
- `key_held` and `key_press` update even when the FIFO overflows.
- Mid-operation reset: all state is lost, including a partial prefix and any queued events.

Decomposition:
- Shared package `ps2_keys_pkg`:
  - scancode constants (E0, F0, E1, FA, AA, EE, FE).
  - the game-key index/code table.
  - a parser-state enum.
  - a function `game_key_idx(ext, code)` returning {hit, idx[2:0]}.
- Sub-module `ps2_event_fifo`: parameterised synchronous FIFO, 11-bit data, with push/pop/full/empty.
- Parser, timeout counter and held map stay in the top level.

Test Plan:
- Make/break: bytes 1C, F0 1C -> events 0x01C then 0x11C (brk=1); `key_held` remains 0 throughout.
- Extended game key: E0 6B, E0 6B, E0 F0 6B -> `key_press`[0] pulses once; events repeat 0, 1, 0 with ext=1, and the final event has brk=1; `key_held`[0] goes 1 then 0.
- Pause and status bytes:
  - AA, FA -> no events.
  - E1 14 77 E1 F0 14 F0 77 -> no events.
  - A following 29 -> event 0x029 and `key_press`[4] pulse.
- Timeout: E0, then no byte for 100000 cycles -> `seq_error` pulse, state IDLE; next byte 75 -> event ext=0 code 75, `key_held`[2]=0.
- Overflow: hold `ev_ready`=0 and send 5 makes -> 4 queued, `ev_overflow`=1. Then pop with `ev_ready`=1 -> first 4 events in order. Also push and pop on the same cycle while full -> no drop.
- Reset: assert `reset_n`=0 asynchronously mid-E0-F0 with 2 events queued -> `ev_valid`=0, `key_held`=0 immediately; after release, byte 6B -> event ext=0.
